keypad_scan: RTL and testbench

4x4 matrix keypad scanner and debouncer that produces the 4-bit key code consumed by the password/drive-mode controller. It drives one keypad column low at a time, samples the row lines, and resolves at most one pressed key per scan frame. It then debounces across whole frames and presents a stable `kb_out` code. The idle code is 4'hf, so the downstream controller can edge-detect presses by code change.

---
 rtl/keypad_scan.sv | 179 +++++++++++++++++
 tb/tb_keypad_scan.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks one active-low column per slot, resolves one key
// per frame with ghost rejection, and debounces across whole frames into kb_out.
module keypad_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] kb_out,
  output logic       key_strobe
);

  localparam int             SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0]     DB        = 8'(DEBOUNCE_FRAMES);
  localparam logic [3:0]     NO_KEY    = 4'hf;

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'ha;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hb;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'ha: key_code = 4'h9;  4'hb: key_code = 4'hc;
      4'hc: key_code = 4'he;  4'hd: key_code = 4'h0;  4'he: key_code = 4'hf;  default: key_code = 4'hd;
    endcase
  endfunction

  logic [3:0]    row_meta_reg, row_sync_reg;
  logic [SW-1:0] slot_reg;
  logic [1:0]    col_reg;
  logic [1:0]    hit_cnt_reg;
  logic [3:0]    hit_code_reg;
  state_t        state_reg, state_next;
  logic [3:0]    cand_reg, cand_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [3:0]    kb_reg, kb_next;
  logic          strobe_reg, strobe_next;

  logic          sample, frame_done;
  logic [3:0]    hit_row;
  logic [2:0]    col_cnt, total;
  logic [3:0]    col_code, frame_code, frame_result;
  logic [7:0]    cnt_inc;

  assign col_out    = ~(4'b0001 << col_reg);
  assign kb_out     = kb_reg;
  assign key_strobe = strobe_reg;
  assign sample     = (slot_reg == SLOT_LAST);
  assign frame_done = sample && (col_reg == 2'd3);

  // Row 3 of column 2 is the '#' position, which never counts as a hit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
      assign hit_row[gi] = !row_sync_reg[gi] && !(gi == 3 && col_reg == 2'd2);
    end
  endgenerate

  always_comb begin
    col_cnt  = 3'(hit_row[0]) + 3'(hit_row[1]) + 3'(hit_row[2]) + 3'(hit_row[3]);
    col_code = NO_KEY;
    for (int r = 3; r >= 0; r--) begin
      if (hit_row[r]) col_code = key_code(2'(r), col_reg);
    end
    total        = {1'b0, hit_cnt_reg} + col_cnt;
    frame_code   = (col_cnt == 3'd1) ? col_code : hit_code_reg;
    frame_result = (total == 3'd1) ? frame_code : NO_KEY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_reg <= 4'hf;
      row_sync_reg <= 4'hf;
      slot_reg     <= '0;
      col_reg      <= 2'd0;
      hit_cnt_reg  <= 2'd0;
      hit_code_reg <= NO_KEY;
    end else begin
      row_meta_reg <= row_in;
      row_sync_reg <= row_meta_reg;
      if (sample) begin
        slot_reg <= '0;
        col_reg  <= col_reg + 2'd1;
        if (frame_done) begin
          hit_cnt_reg  <= 2'd0;
          hit_code_reg <= NO_KEY;
        end else begin
          // Hit count saturates at 2: anything beyond one hit is a ghost.
          hit_cnt_reg  <= (total >= 3'd2) ? 2'd2 : total[1:0];
          hit_code_reg <= frame_code;
        end
      end else begin
        slot_reg <= slot_reg + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= RELEASED;
      cand_reg   <= NO_KEY;
      cnt_reg    <= 8'd0;
      kb_reg     <= NO_KEY;
      strobe_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cand_reg   <= cand_next;
      cnt_reg    <= cnt_next;
      kb_reg     <= kb_next;
      strobe_reg <= strobe_next;
    end
  end

  assign cnt_inc = (cnt_reg == 8'hff) ? 8'hff : cnt_reg + 8'd1;

  always_comb begin
    state_next  = state_reg;
    cand_next   = cand_reg;
    cnt_next    = cnt_reg;
    kb_next     = kb_reg;
    strobe_next = 1'b0;
    if (frame_done) begin
      case (state_reg)
        RELEASED: if (frame_result != NO_KEY) begin
          cand_next = frame_result;
          cnt_next  = 8'd1;
          if (DB == 8'd1) begin
            kb_next     = frame_result;
            strobe_next = 1'b1;
            state_next  = HELD;
          end else begin
            state_next = PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (frame_result == cand_reg) begin
            cnt_next = cnt_inc;
            if (cnt_inc >= DB) begin
              kb_next     = cand_reg;
              strobe_next = 1'b1;
              state_next  = HELD;
            end
          end else if (frame_result == NO_KEY) begin
            cnt_next   = 8'd0;
            state_next = RELEASED;
          end else begin
            cand_next = frame_result;
            cnt_next  = 8'd1;
          end
        end
        HELD: if (frame_result != kb_reg) begin
          cnt_next = 8'd1;
          if (DB == 8'd1) begin
            kb_next    = NO_KEY;
            state_next = RELEASED;
          end else begin
            state_next = RELEASE_CHK;
          end
        end
        default: begin
          // Any other code, including a new key, only advances the release.
          if (frame_result != kb_reg) begin
            cnt_next = cnt_inc;
            if (cnt_inc >= DB) begin
              kb_next    = NO_KEY;
              state_next = RELEASED;
            end
          end else begin
            cnt_next   = 8'd0;
            state_next = HELD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with a behavioural keypad matrix and a strobe scoreboard
// holding the expected code and commit cycle of every press.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] kb_out;
  logic       key_strobe;

  logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c is held
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  typedef struct { logic [3:0] code; int at; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .row_in(row_in),
    .col_out(col_out), .kb_out(kb_out), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Every strobe must match the oldest pending expectation, code and cycle.
  always @(negedge clk) begin
    if (reset && key_strobe) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: kb_out=%h at cyc %0d, required no strobe", kb_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (kb_out !== mon_e.code || cyc != mon_e.at) begin
          errors++;
          $display("FAIL strobe: kb_out=%h cyc=%0d, required %h at cyc %0d", kb_out, cyc, mon_e.code, mon_e.at);
        end else begin
          $display("strobe kb_out=%h cyc=%0d ok", kb_out, cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int target);
    for (int i = 0; i < 2000 && cyc != target; i++) @(negedge clk);
    checks++;
    if (cyc != target) begin
      errors++;
      $display("FAIL wait_until: cyc=%0d, required %0d", cyc, target);
    end
  endtask

  task automatic align(output int base);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (cyc % 16 != 0 && i < 40);
    base = cyc;
  endtask

  task automatic test_reset();
    logic [3:0] one, exp_col;
    one = 4'b0001;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_until(7);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || kb_out !== 4'hf || key_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: col=%b kb=%h stb=%b, required 1110 f 0", col_out, kb_out, key_strobe);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      exp_col = ~(one << (n / 4));
      checks++;
      if (col_out !== exp_col) begin
        errors++;
        $display("FAIL scan_step: cyc=%0d col=%b, required %b", n, col_out, exp_col);
      end
    end
    $display("test_reset done");
  endtask

  task automatic expect_kb(input string name, input int at, input logic [3:0] code);
    wait_until(at);
    checks++;
    if (kb_out !== code) begin
      errors++;
      $display("FAIL %s: kb_out=%h at cyc %0d, required %h", name, kb_out, cyc, code);
    end
  endtask

  task automatic test_single_press();
    int base;
    align(base);
    keys = 16'h0020;
    sb.push_back('{4'h5, base + 48});
    expect_kb("press_before", base + 47, 4'hf);
    expect_kb("press_commit", base + 48, 4'h5);
    expect_kb("press_hold", base + 112, 4'h5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL press_strobe_missing: pending=%0d, required 0", sb.size());
    end
    $display("test_single_press done");
  endtask

  task automatic test_release();
    int base;
    align(base);
    keys = 16'h0;
    expect_kb("release_f2", base + 32, 4'h5);
    expect_kb("release_f3", base + 47, 4'h5);
    expect_kb("release_done", base + 48, 4'hf);
    align(base);
    keys = 16'h0020;
    sb.push_back('{4'h5, base + 48});
    expect_kb("repress", base + 48, 4'h5);
    align(base);
    keys = 16'h0;
    expect_kb("repress_release", base + 48, 4'hf);
    $display("test_release done");
  endtask

  task automatic test_bounce();
    int base;
    align(base);
    for (int i = 0; i < 3; i++) begin
      keys = 16'h0008;
      wait_until(base + 32 * i + 16);
      keys = 16'h0;
      wait_until(base + 32 * i + 32);
    end
    expect_kb("bounce_toggle", base + 96, 4'hf);
    keys = 16'h0008;
    sb.push_back('{4'ha, base + 144});
    expect_kb("bounce_before", base + 143, 4'hf);
    expect_kb("bounce_commit", base + 144, 4'ha);
    align(base);
    keys = 16'h0;
    expect_kb("bounce_release", base + 48, 4'hf);
    $display("test_bounce done");
  endtask

  task automatic test_ghost();
    int base;
    align(base);
    keys = 16'h0401;
    expect_kb("ghost_mid", base + 48, 4'hf);
    expect_kb("ghost_end", base + 80, 4'hf);
    keys = 16'h4000;
    expect_kb("hash_mid", base + 128, 4'hf);
    expect_kb("hash_end", base + 160, 4'hf);
    keys = 16'h0;
    $display("test_ghost done");
  endtask

  task automatic test_key_change();
    int base;
    align(base);
    keys = 16'h0002;
    sb.push_back('{4'h2, base + 48});
    expect_kb("change_commit2", base + 48, 4'h2);
    align(base);
    keys = 16'h2000;
    expect_kb("change_hold2", base + 47, 4'h2);
    expect_kb("change_release2", base + 48, 4'hf);
    sb.push_back('{4'h0, base + 96});
    expect_kb("change_before0", base + 95, 4'hf);
    expect_kb("change_commit0", base + 96, 4'h0);
    align(base);
    keys = 16'h0;
    expect_kb("change_release0", base + 48, 4'hf);
    $display("test_key_change done");
  endtask

  task automatic test_reset_mid();
    int base;
    align(base);
    keys = 16'h0020;
    sb.push_back('{4'h5, base + 48});
    expect_kb("mid_commit", base + 48, 4'h5);
    wait_until(base + 70);
    #2 reset = 1'b0;
    keys = 16'h0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || kb_out !== 4'hf || key_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: col=%b kb=%h stb=%b, required 1110 f 0", col_out, kb_out, key_strobe);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    expect_kb("after_reset", 80, 4'hf);
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_ghost();
    test_key_change();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_strobes: %0d left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
